pipe_chain: RTL

PIPE_CHAIN -- requirements
Module: pipe_chain

---
 rtl/pipe_chain.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipe_chain.sv
// Write-back pipeline of DEPTH stages with per-stage forwarding lookup and occupancy count.
// Latency: DEPTH cycles from the cycle a packet is presented and accepted to out_valid_o, 1 packet/cycle.
// Backpressure: bubble-collapsing valid/ready chain; a stage advances when empty or when everything ahead moves.
module pipe_chain #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [RADDR_W-1:0]         in_waddr_i,
  input  logic                       in_we_i,
  input  logic [DATA_W-1:0]          in_wdata_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [RADDR_W-1:0]         out_waddr_o,
  output logic                       out_we_o,
  output logic [DATA_W-1:0]          out_wdata_o,
  input  logic                       flush_i,
  input  logic [RADDR_W-1:0]         fwd_raddr_i,
  output logic                       fwd_hit_o,
  output logic [DATA_W-1:0]          fwd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] occ_o
);

  localparam int OCC_W = $clog2(DEPTH+1);

  // Stage 0 is the youngest, stage DEPTH-1 the oldest.
  logic [DEPTH-1:0]   valid;
  logic [DEPTH-1:0]   we;
  logic [RADDR_W-1:0] waddr [DEPTH];
  logic [DATA_W-1:0]  wdata [DEPTH];
  logic [DEPTH-1:0]   ready;

  // Ready chain in closed form: a stage can load if any stage from it to the end has a hole,
  // or if the downstream port is taking the oldest packet.
  always_comb begin
    logic acc;
    acc   = out_ready_i;
    ready = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc      = acc | ~valid[k];
      ready[k] = acc;
    end
  end

  // Stage registers: flush wins over every advance; otherwise each ready stage takes its upstream.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= '0;
      we    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        waddr[k] <= '0;
        wdata[k] <= '0;
      end
    end else if (flush_i) begin
      valid <= '0;
    end else begin
      if (ready[0]) begin
        valid[0] <= in_valid_i;
        we[0]    <= in_we_i;
        waddr[0] <= in_waddr_i;
        wdata[0] <= in_wdata_i;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (ready[k]) begin
          valid[k] <= valid[k-1];
          we[k]    <= we[k-1];
          waddr[k] <= waddr[k-1];
          wdata[k] <= wdata[k-1];
        end
      end
    end
  end

  // Forwarding lookup over stages only; scanning oldest to youngest lets the youngest match win.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid[k] && we[k] && (waddr[k] == fwd_raddr_i) && (fwd_raddr_i != '0)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = wdata[k];
      end
    end
  end

  // Occupancy: population count of the stage valid bits.
  always_comb begin
    occ_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_o = occ_o + OCC_W'(valid[k]);
    end
  end

  assign in_ready_o  = ready[0];
  assign out_valid_o = valid[DEPTH-1];
  assign out_we_o    = we[DEPTH-1] & valid[DEPTH-1];
  assign out_waddr_o = waddr[DEPTH-1];
  assign out_wdata_o = wdata[DEPTH-1];

endmodule
